// File: rtl/speaker_tone_out.sv
`default_nettype none
// ============================================================================
// Module : speaker_tone_out
// Two-channel square-wave tone generator serialised as a left-justified
// Pmod audio DAC stream (mclk/lrck/sck/sdin).
// Rev    : 1.0 - initial release
// ============================================================================
module speaker_tone_out #(
  parameter int unsigned      DIV_W      = 26,
  parameter logic [DIV_W-1:0] SILENT_DIV = DIV_W'(50_000_000),
  parameter logic [15:0]      AMP_STEP   = 16'h1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] freqL,
  input  logic [DIV_W-1:0] freqR,
  input  logic [2:0]       vol,
  output logic             mclk,
  output logic             lrck,
  output logic             sck,
  output logic             sdin
);

  localparam logic [8:0] c_FRAME_LAST = 9'd511;

  logic [DIV_W-1:0] w_freq   [2];
  logic [15:0]      w_sample [2];
  logic [15:0]      w_amp;

  assign w_freq[0] = freqL;
  assign w_freq[1] = freqR;
  assign w_amp     = 16'(vol) * AMP_STEP;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [DIV_W-1:0] r_div;
      logic [DIV_W-1:0] r_cnt;
      logic             r_bit;
      logic             w_silent;
      logic [DIV_W-1:0] w_lim_d;
      logic [DIV_W-1:0] w_lim_f;
      logic [DIV_W-1:0] w_lim;

      assign w_silent = (r_div < DIV_W'(2)) || (r_div >= SILENT_DIV);
      assign w_lim_d  = (r_div >> 1) - DIV_W'(1);
      // A live divider below 2 wraps to all-ones here, so it never wins the min.
      assign w_lim_f  = (w_freq[g] >> 1) - DIV_W'(1);
      // The latched divider bounds the half-period; a smaller live divider cuts it short.
      assign w_lim    = (w_lim_f < w_lim_d) ? w_lim_f : w_lim_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_div <= '0;
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (w_silent) begin
          r_div <= w_freq[g];
          r_cnt <= '0;
          r_bit <= 1'b0;
        end else if (r_cnt >= w_lim) begin
          r_div <= w_freq[g];
          r_cnt <= '0;
          r_bit <= ~r_bit;
        end else begin
          r_cnt <= r_cnt + DIV_W'(1);
        end
      end

      assign w_sample[g] = w_silent ? 16'h0000 : (r_bit ? w_amp : 16'h0000 - w_amp);
    end
  endgenerate

  logic [8:0]  r_fc;
  logic [15:0] r_lat_l;
  logic [15:0] r_lat_r;
  logic        r_sdin;
  logic [8:0]  w_nfc;
  logic        w_frame_end;
  logic [15:0] w_lat_l_nxt;
  logic [15:0] w_lat_r_nxt;
  logic [15:0] w_word;
  logic [3:0]  w_idx;

  assign w_nfc       = r_fc + 9'd1;
  assign w_frame_end = (r_fc == c_FRAME_LAST);
  assign w_lat_l_nxt = w_frame_end ? w_sample[0] : r_lat_l;
  assign w_lat_r_nxt = w_frame_end ? w_sample[1] : r_lat_r;
  // The bit loaded at a slot boundary belongs to the slot that starts next.
  assign w_word      = w_nfc[8] ? w_lat_r_nxt : w_lat_l_nxt;
  assign w_idx       = ~w_nfc[7:4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fc    <= '0;
      r_lat_l <= '0;
      r_lat_r <= '0;
      r_sdin  <= 1'b0;
    end else begin
      r_fc    <= w_nfc;
      r_lat_l <= w_lat_l_nxt;
      r_lat_r <= w_lat_r_nxt;
      if (r_fc[3:0] == 4'hF) begin
        r_sdin <= w_word[w_idx];
      end
    end
  end

  assign mclk = r_fc[1];
  assign sck  = r_fc[3];
  assign lrck = r_fc[8];
  assign sdin = r_sdin;

endmodule
`default_nettype wire

// File: tb/tb_speaker_tone_out.sv
`default_nettype none
// ============================================================================
// Module : tb_speaker_tone_out
// Self-checking bench: decodes the serial DAC stream frame by frame and
// compares it against a behavioural tone/frame model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_speaker_tone_out;

  localparam int C_SILENT = 50_000_000;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [25:0] freqL = 26'd50_000_000;
  logic [25:0] freqR = 26'd50_000_000;
  logic [2:0]  vol   = 3'd7;
  logic        mclk, lrck, sck, sdin;

  speaker_tone_out #(
    .DIV_W     (26),
    .SILENT_DIV(26'd50_000_000),
    .AMP_STEP  (16'h1000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .freqL(freqL),
    .freqR(freqR),
    .vol  (vol),
    .mclk (mclk),
    .lrck (lrck),
    .sck  (sck),
    .sdin (sdin)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] got_l;
    logic [15:0] got_r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } frame_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_fc;
  int          m_div [2];
  int          m_el  [2];
  bit          m_b   [2];
  logic [15:0] m_lat [2];
  logic [31:0] rx;
  frame_t      q_frames [$];
  int          clk_err = 0;
  int          clk_err_fc = 0;

  function automatic void model_reset();
    m_fc = 0;
    for (int c = 0; c < 2; c++) begin
      m_div[c] = 0;
      m_el[c]  = 0;
      m_b[c]   = 1'b0;
      m_lat[c] = 16'h0000;
    end
    rx = '0;
  endfunction

  // Signed sample value of a channel as the spec defines it, from the current volume.
  function automatic logic [15:0] f_sample(int ch);
    int amp;
    amp = int'(vol) * 4096;
    if (m_div[ch] < 2 || m_div[ch] >= C_SILENT) return 16'h0000;
    return m_b[ch] ? 16'(amp) : 16'(-amp);
  endfunction

  // Half-period bookkeeping in elapsed cycles; a smaller live divider shortens the current half.
  function automatic void f_tone(int ch, int freq);
    int half;
    if (m_div[ch] < 2 || m_div[ch] >= C_SILENT) begin
      m_b[ch]   = 1'b0;
      m_el[ch]  = 0;
      m_div[ch] = freq;
      return;
    end
    half = m_div[ch] / 2;
    if (freq >= 2 && freq / 2 < half) half = freq / 2;
    m_el[ch]++;
    if (m_el[ch] >= half) begin
      m_b[ch]   = !m_b[ch];
      m_el[ch]  = 0;
      m_div[ch] = freq;
    end
  endfunction

  // Advance the model one clock, then observe the DUT on the falling edge.
  task automatic step();
    logic [8:0] fcv;
    if (m_fc == 511) begin
      m_lat[0] = f_sample(0);
      m_lat[1] = f_sample(1);
    end
    f_tone(0, int'(freqL));
    f_tone(1, int'(freqR));
    m_fc = (m_fc + 1) % 512;
    @(posedge clk);
    @(negedge clk);
    fcv = 9'(m_fc);
    if ({mclk, sck, lrck} !== {fcv[1], fcv[3], fcv[8]}) begin
      if (clk_err == 0) clk_err_fc = m_fc;
      clk_err++;
    end
    if (fcv[3:0] == 4'd8) rx[5'd31 - fcv[8:4]] = sdin;
    if (m_fc == 504) q_frames.push_back(frame_t'({rx[31:16], rx[15:0], m_lat[0], m_lat[1]}));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    freqL = 26'd50_000_000;
    freqR = 26'd50_000_000;
    vol   = 3'd7;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mclk, lrck, sck, sdin} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got {mclk,lrck,sck,sdin}=%b want 0000", {mclk, lrck, sck, sdin});
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_silent();
    frame_t f;
    run(10 * 512);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      n_cmp++;
      if ({f.got_l, f.got_r} !== 32'h0) begin
        n_fail++;
        $display("FAIL silent_frame: got L=%h R=%h want L=0000 R=0000", f.got_l, f.got_r);
      end
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL silent_model: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    n_cmp++;
    if (clk_err !== 0) begin
      n_fail++;
      $display("FAIL silent_clocks: got %0d bad cycles (first fc=%0d) want 0", clk_err, clk_err_fc);
    end
    clk_err = 0;
  endtask

  task automatic test_tone_1000();
    frame_t f;
    bit seen_pos = 1'b0;
    bit seen_neg = 1'b0;
    freqL = 26'd1000;
    vol   = 3'd1;
    run(8 * 512);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      if (f.got_l == 16'h1000) seen_pos = 1'b1;
      if (f.got_l == 16'hF000) seen_neg = 1'b1;
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL tone1000_frame: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    n_cmp++;
    if ({seen_pos, seen_neg} !== 2'b11) begin
      n_fail++;
      $display("FAIL tone1000_polarity: got seen{1000,F000}=%b want 11", {seen_pos, seen_neg});
    end
    n_cmp++;
    if (clk_err !== 0) begin
      n_fail++;
      $display("FAIL tone1000_clocks: got %0d bad cycles (first fc=%0d) want 0", clk_err, clk_err_fc);
    end
    clk_err = 0;
  endtask

  task automatic test_shrink();
    frame_t f;
    bit seen_pos = 1'b0;
    bit seen_neg = 1'b0;
    freqL = 26'd100000;
    vol   = 3'd2;
    run(1500);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL shrink_before: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    freqL = 26'd200;
    run(6 * 512);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      if (f.got_l == 16'h2000) seen_pos = 1'b1;
      if (f.got_l == 16'hE000) seen_neg = 1'b1;
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL shrink_after: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    n_cmp++;
    if ({seen_pos, seen_neg} !== 2'b11) begin
      n_fail++;
      $display("FAIL shrink_polarity: got seen{2000,E000}=%b want 11", {seen_pos, seen_neg});
    end
    clk_err = 0;
  endtask

  task automatic test_vol_change();
    frame_t f;
    freqL = 26'd1000;
    vol   = 3'd3;
    run(1200);
    while (m_fc != 100) step();
    q_frames.delete();
    vol = 3'd5;
    run(404);
    n_cmp++;
    if (q_frames.size() != 1) begin
      n_fail++;
      $display("FAIL vol_frame_count: got %0d frames want 1", q_frames.size());
    end else begin
      f = q_frames.pop_front();
      n_cmp++;
      if (f.got_l !== 16'h3000 && f.got_l !== 16'hD000) begin
        n_fail++;
        $display("FAIL vol_current: got L=%h want 3000 or D000", f.got_l);
      end
    end
    run(512);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      n_cmp++;
      if (f.got_l !== 16'h5000 && f.got_l !== 16'hB000) begin
        n_fail++;
        $display("FAIL vol_next: got L=%h want 5000 or B000", f.got_l);
      end
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL vol_model: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    clk_err = 0;
  endtask

  task automatic test_fast_right();
    frame_t f;
    int k = 0;
    freqR = 26'd2;
    vol   = 3'd7;
    run(5 * 512);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      if (k >= 2) begin
        n_cmp++;
        if (f.got_r !== 16'h7000 && f.got_r !== 16'h9000) begin
          n_fail++;
          $display("FAIL fast_right_word: got R=%h want 7000 or 9000", f.got_r);
        end
      end
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL fast_right_model: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
      k++;
    end
    n_cmp++;
    if (clk_err !== 0) begin
      n_fail++;
      $display("FAIL fast_right_clocks: got %0d bad cycles (first fc=%0d) want 0", clk_err, clk_err_fc);
    end
    clk_err = 0;
  endtask

  task automatic test_mid_reset();
    frame_t f;
    int k = 0;
    freqL = 26'd600;
    freqR = 26'd900;
    vol   = 3'd6;
    run(700);
    while (m_fc != 300) step();
    q_frames.delete();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({mclk, lrck, sck, sdin} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got {mclk,lrck,sck,sdin}=%b want 0000", {mclk, lrck, sck, sdin});
    end
    repeat (7) @(negedge clk);
    n_cmp++;
    if ({mclk, lrck, sck, sdin} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got {mclk,lrck,sck,sdin}=%b want 0000", {mclk, lrck, sck, sdin});
    end
    model_reset();
    rst = 1'b1;
    run(1100);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      if (k == 0) begin
        n_cmp++;
        if ({f.got_l, f.got_r} !== 32'h0) begin
          n_fail++;
          $display("FAIL mid_reset_first_frame: got L=%h R=%h want L=0000 R=0000", f.got_l, f.got_r);
        end
      end
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL mid_reset_model: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
      k++;
    end
    n_cmp++;
    if (clk_err !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_clocks: got %0d bad cycles (first fc=%0d) want 0", clk_err, clk_err_fc);
    end
    clk_err = 0;
  endtask

  task automatic test_random();
    frame_t f;
    int sel;
    for (int it = 0; it < 10; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      freqL = 26'd50_000_000;
      else if (sel == 1) freqL = 26'($urandom_range(0, 3));
      else               freqL = 26'($urandom_range(2, 2500));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      freqR = 26'd60_000_000;
      else if (sel == 1) freqR = 26'($urandom_range(0, 3));
      else               freqR = 26'($urandom_range(2, 2500));
      vol = 3'($urandom_range(0, 7));
      run(int'($urandom_range(200, 1500)));
    end
    run(1024);
    while (q_frames.size() > 0) begin
      f = q_frames.pop_front();
      n_cmp++;
      if ({f.got_l, f.got_r} !== {f.exp_l, f.exp_r}) begin
        n_fail++;
        $display("FAIL random_frame: got L=%h R=%h want L=%h R=%h", f.got_l, f.got_r, f.exp_l, f.exp_r);
      end
    end
    n_cmp++;
    if (clk_err !== 0) begin
      n_fail++;
      $display("FAIL random_clocks: got %0d bad cycles (first fc=%0d) want 0", clk_err, clk_err_fc);
    end
    clk_err = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_silent();
    test_tone_1000();
    test_shrink();
    test_vol_change();
    test_fast_right();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
